gate_sweep_checker: RTL and testbench



---
 rtl/gate_sweep_checker.sv | 142 ++++++++++++++
 tb/tb_gate_sweep_checker.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// Sweeps every input vector of a combinational gate, samples its output and checks it against a latched truth table.
// Optional macro GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module gate_sweep_checker #(
   parameter int N_INPUTS = 2,
   parameter int SETTLE   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [(1 << N_INPUTS)-1:0]   expected,
   input  logic                         dut_out,
   output logic [N_INPUTS-1:0]          stim,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [(1 << N_INPUTS)-1:0]   captured,
   output logic                         fail_valid,
   output logic [N_INPUTS-1:0]          fail_index
);

   localparam int V  = 1 << N_INPUTS;
   localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [CW-1:0]       CNT_INIT = CW'(SETTLE);
   localparam logic [N_INPUTS-1:0] LAST_VEC = N_INPUTS'(V - 1);

   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N_INPUTS-1:0] stim_q, stim_d;
   logic [V-1:0]        exp_q, exp_d;
   logic [V-1:0]        captured_q, captured_d;
   logic                fail_valid_q, fail_valid_d;
   logic [N_INPUTS-1:0] fail_index_q, fail_index_d;
   logic                pass_q, pass_d;
   logic                mismatch;

   assign mismatch = (dut_out != exp_q[stim_q]);

   // pass is resolved on the edge that enters DONE so it is already valid while done is high.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stim_d       = stim_q;
      exp_d        = exp_q;
      captured_d   = captured_q;
      fail_valid_d = fail_valid_q;
      fail_index_d = fail_index_q;
      pass_d       = pass_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               exp_d        = expected;
               stim_d       = '0;
               cnt_d        = CNT_INIT;
               captured_d   = '0;
               fail_valid_d = 1'b0;
               fail_index_d = '0;
               pass_d       = 1'b0;
               state_d      = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_SAMPLE: begin
            captured_d[stim_q] = dut_out;
            if (mismatch && !fail_valid_q) begin
               fail_valid_d = 1'b1;
               fail_index_d = stim_q;
            end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
            if (mismatch && !fail_valid_q) begin
               pass_d  = 1'b0;
               state_d = S_DONE;
            end else if (stim_q == LAST_VEC) begin
               pass_d  = !(fail_valid_q || mismatch);
               state_d = S_DONE;
            end else begin
               stim_d  = stim_q + 1'b1;
               cnt_d   = CNT_INIT;
               state_d = S_SETTLE;
            end
`else
            if (stim_q == LAST_VEC) begin
               pass_d  = !(fail_valid_q || mismatch);
               state_d = S_DONE;
            end else begin
               stim_d  = stim_q + 1'b1;
               cnt_d   = CNT_INIT;
               state_d = S_SETTLE;
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         stim_q       <= '0;
         exp_q        <= '0;
         captured_q   <= '0;
         fail_valid_q <= 1'b0;
         fail_index_q <= '0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         stim_q       <= stim_d;
         exp_q        <= exp_d;
         captured_q   <= captured_d;
         fail_valid_q <= fail_valid_d;
         fail_index_q <= fail_index_d;
         pass_q       <= pass_d;
      end
   end

   assign stim       = stim_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign pass       = pass_q;
   assign captured   = captured_q;
   assign fail_valid = fail_valid_q;
   assign fail_index = fail_index_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench for gate_sweep_checker: a truth-table gate model drives dut_out, and a
// sweep-level reference model predicts results (honours GATE_SWEEP_STOP_ON_FAIL_EN when defined).
module tb_gate_sweep_checker;

   localparam int N   = 2;
   localparam int S   = 2;
   localparam int V   = 1 << N;
   localparam int PER = S + 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [V-1:0] expected;
   logic [V-1:0] gate_tt;
   logic         dut_out;
   logic [N-1:0] stim;
   logic         busy;
   logic         done;
   logic         pass;
   logic [V-1:0] captured;
   logic         fail_valid;
   logic [N-1:0] fail_index;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model results
   logic [V-1:0] m_captured;
   logic         m_pass;
   logic         m_fv;
   logic [N-1:0] m_fi;
   logic [N-1:0] m_stim;
   int           m_cycles;

   // Observations from the most recent sweep
   int           obs_cycles;
   logic         obs_timeout;
   logic         obs_stim_bad;
   logic         obs_busy_bad;
   logic [V-1:0] obs_captured;
   logic         obs_pass;
   logic         obs_fv;
   logic [N-1:0] obs_fi;
   logic [N-1:0] obs_stim;
   logic         obs_busy_after;
   logic         obs_done_after;

   gate_sweep_checker #(.N_INPUTS(N), .SETTLE(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .expected   (expected),
      .dut_out    (dut_out),
      .stim       (stim),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .captured   (captured),
      .fail_valid (fail_valid),
      .fail_index (fail_index)
   );

   always #5 clk = ~clk;

   assign dut_out = gate_tt[stim];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic model_sweep(input logic [V-1:0] exp_v, input logic [V-1:0] gate);
      int first;
      first = -1;
      for (int i = 0; i < V; i++) begin
         if (gate[i] !== exp_v[i] && first < 0) first = i;
      end
      m_fv       = (first >= 0);
      m_fi       = (first >= 0) ? N'(first) : '0;
      m_pass     = (first < 0);
      m_cycles   = V * PER;
      m_stim     = N'(V - 1);
      m_captured = gate;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
      if (first >= 0) begin
         m_cycles   = (first + 1) * PER;
         m_stim     = N'(first);
         m_captured = '0;
         for (int i = 0; i <= first; i++) m_captured[i] = gate[i];
      end
`endif
   endtask

   // Runs one sweep; k counts edges since the accepting edge, sampled 1ns after each edge.
   task automatic drive_sweep(input logic [V-1:0] exp_v, input logic [V-1:0] gate,
                              input logic hold, input int change_at);
      int k;
      model_sweep(exp_v, gate);
      gate_tt = gate;
      @(negedge clk);
      expected = exp_v;
      start    = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      k            = 0;
      obs_stim_bad = 1'b0;
      obs_busy_bad = 1'b0;
      obs_timeout  = 1'b0;
      while (done !== 1'b1) begin
         if (k >= 300) begin
            obs_timeout = 1'b1;
            break;
         end
         if (stim !== N'(k / PER)) obs_stim_bad = 1'b1;
         if (busy !== 1'b1) obs_busy_bad = 1'b1;
         if (k == change_at) expected = '0;
         @(posedge clk);
         #1;
         k++;
      end
      if (busy !== 1'b1) obs_busy_bad = 1'b1;
      obs_cycles   = k;
      obs_captured = captured;
      obs_pass     = pass;
      obs_fv       = fail_valid;
      obs_fi       = fail_index;
      obs_stim     = stim;
      @(posedge clk);
      #1;
      obs_busy_after = busy;
      obs_done_after = done;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      start    = 1'b0;
      expected = '0;
      gate_tt  = '0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({stim, busy, done} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_ctrl: got stim/busy/done=%b want 0", {stim, busy, done});
      end
      tests_run++;
      if ({pass, captured, fail_valid, fail_index} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_result: got %b want 0", {pass, captured, fail_valid, fail_index});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_and_pass();
      drive_sweep(4'b1000, 4'b1000, 1'b0, -1);
      tests_run++;
      if (obs_timeout || obs_cycles != 16) begin
         tests_failed++;
         $display("[TB] FAIL and_done_time: got %0d want 16", obs_cycles);
      end
      tests_run++;
      if (obs_stim_bad || obs_busy_bad) begin
         tests_failed++;
         $display("[TB] FAIL and_stim_seq: got stim_bad=%b busy_bad=%b want 0", obs_stim_bad, obs_busy_bad);
      end
      tests_run++;
      if ({obs_pass, obs_captured, obs_fv, obs_fi} !== {1'b1, 4'b1000, 1'b0, 2'd0}) begin
         tests_failed++;
         $display("[TB] FAIL and_result: got pass=%b cap=%b fv=%b fi=%0d want 1 1000 0 0",
                  obs_pass, obs_captured, obs_fv, obs_fi);
      end
      tests_run++;
      if ({obs_busy_after, obs_done_after} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL and_after_done: got busy/done=%b want 00", {obs_busy_after, obs_done_after});
      end
   endtask

   task automatic test_mismatch();
      drive_sweep(4'b1110, 4'b1000, 1'b0, -1);
      tests_run++;
      if (obs_timeout || obs_cycles != m_cycles) begin
         tests_failed++;
         $display("[TB] FAIL mism_done_time: got %0d want %0d", obs_cycles, m_cycles);
      end
      tests_run++;
      if (obs_captured !== m_captured) begin
         tests_failed++;
         $display("[TB] FAIL mism_captured: got %b want %b", obs_captured, m_captured);
      end
      tests_run++;
      if ({obs_pass, obs_fv, obs_fi} !== {1'b0, 1'b1, 2'd1}) begin
         tests_failed++;
         $display("[TB] FAIL mism_flags: got pass=%b fv=%b fi=%0d want 0 1 1", obs_pass, obs_fv, obs_fi);
      end
      tests_run++;
      if (obs_stim !== m_stim) begin
         tests_failed++;
         $display("[TB] FAIL mism_stim_hold: got %0d want %0d", obs_stim, m_stim);
      end
   endtask

   task automatic test_mid_reset();
      int seen;
      gate_tt = 4'b0111;
      @(negedge clk);
      expected = 4'b0111;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tests_run++;
      if ({stim, busy, done} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL midrst_ctrl: got stim/busy/done=%b want 0", {stim, busy, done});
      end
      tests_run++;
      if ({pass, captured, fail_valid, fail_index} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL midrst_result: got %b want 0", {pass, captured, fail_valid, fail_index});
      end
      seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      tests_run++;
      if (seen != 0) begin
         tests_failed++;
         $display("[TB] FAIL midrst_no_done: got %0d active cycles want 0", seen);
      end
      drive_sweep(4'b0111, 4'b0111, 1'b0, -1);
      tests_run++;
      if (obs_timeout || obs_cycles != 16 || obs_stim_bad ||
          {obs_pass, obs_captured, obs_fv} !== {1'b1, 4'b0111, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL midrst_resweep: got cyc=%0d pass=%b cap=%b fv=%b want 16 1 0111 0",
                  obs_cycles, obs_pass, obs_captured, obs_fv);
      end
   endtask

   task automatic test_back_to_back();
      drive_sweep(4'b1000, 4'b1000, 1'b1, -1);
      tests_run++;
      if (obs_timeout || obs_cycles != 16 || obs_busy_bad || obs_stim_bad) begin
         tests_failed++;
         $display("[TB] FAIL b2b_first: got cyc=%0d busy_bad=%b stim_bad=%b want 16 0 0",
                  obs_cycles, obs_busy_bad, obs_stim_bad);
      end
      tests_run++;
      if ({obs_busy_after, obs_done_after} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL b2b_idle_gap: got busy/done=%b want 00", {obs_busy_after, obs_done_after});
      end
      drive_sweep(4'b1000, 4'b1000, 1'b1, -1);
      start = 1'b0;
      tests_run++;
      if (obs_timeout || obs_cycles != 16 || obs_busy_bad || obs_stim_bad || obs_pass !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL b2b_second: got cyc=%0d busy_bad=%b stim_bad=%b pass=%b want 16 0 0 1",
                  obs_cycles, obs_busy_bad, obs_stim_bad, obs_pass);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_expected_change();
      drive_sweep(4'b1000, 4'b1000, 1'b0, 5);
      tests_run++;
      if (obs_timeout || {obs_pass, obs_captured, obs_fv} !== {1'b1, 4'b1000, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL exp_change: got pass=%b cap=%b fv=%b want 1 1000 0",
                  obs_pass, obs_captured, obs_fv);
      end
   endtask

   task automatic test_random();
      logic [V-1:0] g;
      logic [V-1:0] e;
      for (int it = 0; it < 12; it++) begin
         g = V'($urandom_range(0, (1 << V) - 1));
         e = ($urandom_range(0, 1) == 0) ? g : V'($urandom_range(0, (1 << V) - 1));
         drive_sweep(e, g, 1'b0, -1);
         tests_run++;
         if (obs_timeout || obs_stim_bad || obs_busy_bad || obs_cycles != m_cycles ||
             {obs_captured, obs_pass, obs_fv, obs_fi, obs_stim} !==
             {m_captured, m_pass, m_fv, m_fi, m_stim}) begin
            tests_failed++;
            $display("[TB] FAIL random_%0d: got cyc=%0d cap=%b pass=%b fv=%b fi=%0d stim=%0d want cyc=%0d cap=%b pass=%b fv=%b fi=%0d stim=%0d",
                     it, obs_cycles, obs_captured, obs_pass, obs_fv, obs_fi, obs_stim,
                     m_cycles, m_captured, m_pass, m_fv, m_fi, m_stim);
         end
      end
   endtask

   initial begin
      test_reset();
      test_and_pass();
      test_mismatch();
      test_mid_reset();
      test_back_to_back();
      test_expected_change();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
